// File: rtl/hazard_controller.sv
// hazard_controller
//   Sequences the 5-stage pipeline around hazards that forwarding cannot
//   resolve: data-memory wait states, mul/div occupancy, load-use and
//   branch-compare dependencies in ID. All stall/bubble/flush outputs are
//   combinational from the current inputs plus registered state (md_busy,
//   memory wait counter, sticky MemErr).
//
// Optional feature: define HAZARD_PERF_EN to add the StallCycles and
//   FlushCount performance counters (CNT_W bits, saturating).
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   IfIdRegRs/Rt, IdUsesRt     sources of the ID instruction
//   IdBranch, BranchTaken      ID branch and its compare result
//   IdMulDiv, IdReadsHiLo      ID is mult/div, ID is mfhi/mflo
//   IdExMemRead/RegWrite/RegRd EX-stage controls and destination
//   ExMemMemRead/MemWrite/RegRd MEM-stage access and destination
//   DMemReady, MdDone          memory completion, mul/div result pulse
//   PcWrite, IfIdWrite         front-end update enables
//   IfIdFlush, IdExBubble      squash IF/ID, insert NOP into ID/EX
//   ExMemHold, MemWbBubble     freeze EX/MEM + ID/EX, NOP into MEM/WB
//   MdStart                    1-cycle mul/div start pulse
//   MemErr                     sticky memory-timeout error
//   StallCycles, FlushCount    performance counters (HAZARD_PERF_EN only)

module hazard_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IfIdRegRs,
  input  logic [4:0]       IfIdRegRt,
  input  logic             IdUsesRt,
  input  logic             IdBranch,
  input  logic             BranchTaken,
  input  logic             IdMulDiv,
  input  logic             IdReadsHiLo,
  input  logic             IdExMemRead,
  input  logic             IdExRegWrite,
  input  logic [4:0]       IdExRegRd,
  input  logic             ExMemMemRead,
  input  logic             ExMemMemWrite,
  input  logic [4:0]       ExMemRegRd,
  input  logic             DMemReady,
  input  logic             MdDone,
  output logic             PcWrite,
  output logic             IfIdWrite,
  output logic             IfIdFlush,
  output logic             IdExBubble,
  output logic             ExMemHold,
  output logic             MemWbBubble,
  output logic             MdStart,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount,
`endif
  output logic             MemErr
);

  // MEM_TIMEOUT is limited to 1..255, so an 8-bit counter always suffices.
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  logic       md_busy;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;
  logic       mem_err;

  logic mem_wait, md_stall, load_use, br_stall, any_stall;
  logic md_start;

  // Source match against a producer destination; $0 never creates a hazard.
  function automatic logic dep_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic use_rt);
    return (r != 5'd0) && ((r == rs) || (use_rt && (r == rt)));
  endfunction

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_wait = (ExMemMemRead | ExMemMemWrite) & ~DMemReady;
    md_stall = md_busy & (IdMulDiv | IdReadsHiLo);
    load_use = IdExMemRead & dep_match(IdExRegRd, IfIdRegRs, IfIdRegRt, IdUsesRt);
    // Branches compare in ID and always read both rs and rt.
    br_stall = IdBranch &
               ((IdExRegWrite & dep_match(IdExRegRd,  IfIdRegRs, IfIdRegRt, 1'b1)) |
                (ExMemMemRead & dep_match(ExMemRegRd, IfIdRegRs, IfIdRegRt, 1'b1)));
    any_stall = mem_wait | md_stall | load_use | br_stall;
  end

  // A mult/div only starts when it actually leaves ID this cycle; starting it
  // while any stall holds ID would re-issue it on the following cycle.
  assign md_start = rst_n & IdMulDiv & ~md_busy & ~any_stall;

  // ---------------------------------------------------------------------------
  // Pipeline controls (priority: mem wait > md > load-use > branch > none)
  // ---------------------------------------------------------------------------
  always_comb begin
    PcWrite     = 1'b1;
    IfIdWrite   = 1'b1;
    IfIdFlush   = 1'b0;
    IdExBubble  = 1'b0;
    ExMemHold   = 1'b0;
    MemWbBubble = 1'b0;
    MdStart     = 1'b0;
    if (rst_n) begin
      if (mem_wait) begin
        // Whole pipe freezes; MEM/WB gets a NOP so WB does not repeat.
        PcWrite     = 1'b0;
        IfIdWrite   = 1'b0;
        ExMemHold   = 1'b1;
        MemWbBubble = 1'b1;
      end else if (md_stall | load_use | br_stall) begin
        PcWrite    = 1'b0;
        IfIdWrite  = 1'b0;
        IdExBubble = 1'b1;
      end else begin
        IfIdFlush = IdBranch & BranchTaken;
        MdStart   = md_start;
      end
    end
  end

  assign MemErr = mem_err;

  // ---------------------------------------------------------------------------
  // Mul/div occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_busy <= 1'b0;
    end else if (md_start) begin
      md_busy <= 1'b1;
    end else if (MdDone) begin
      // MdDone while idle is a stray pulse and has no effect.
      md_busy <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory wait counter and sticky timeout error
  // ---------------------------------------------------------------------------
  // Counter saturates at the timeout so a long wait cannot wrap.
  assign wait_cnt_nxt = (wait_cnt == TIMEOUT) ? wait_cnt : wait_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else if (mem_wait) begin
      wait_cnt <= wait_cnt_nxt;
      if (wait_cnt_nxt == TIMEOUT) mem_err <= 1'b1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end

`ifdef HAZARD_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!PcWrite && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      if (IfIdFlush && !(&flush_count)) flush_count  <= flush_count + 1'b1;
    end
  end

  assign StallCycles = stall_cycles;
  assign FlushCount  = flush_count;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios followed by
// randomized traffic, all checked against a rule-level reference model.
module tb_hazard_controller;
  localparam int TO    = 4;
  localparam int CNT_W = 16;

  logic clk, rst_n;
  logic [4:0] IfIdRegRs, IfIdRegRt, IdExRegRd, ExMemRegRd;
  logic IdUsesRt, IdBranch, BranchTaken, IdMulDiv, IdReadsHiLo;
  logic IdExMemRead, IdExRegWrite, ExMemMemRead, ExMemMemWrite, DMemReady, MdDone;
  logic PcWrite, IfIdWrite, IfIdFlush, IdExBubble, ExMemHold, MemWbBubble, MdStart, MemErr;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] StallCycles, FlushCount;
`endif

  hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .IfIdRegRs(IfIdRegRs), .IfIdRegRt(IfIdRegRt), .IdUsesRt(IdUsesRt),
    .IdBranch(IdBranch), .BranchTaken(BranchTaken), .IdMulDiv(IdMulDiv),
    .IdReadsHiLo(IdReadsHiLo), .IdExMemRead(IdExMemRead), .IdExRegWrite(IdExRegWrite),
    .IdExRegRd(IdExRegRd), .ExMemMemRead(ExMemMemRead), .ExMemMemWrite(ExMemMemWrite),
    .ExMemRegRd(ExMemRegRd), .DMemReady(DMemReady), .MdDone(MdDone),
    .PcWrite(PcWrite), .IfIdWrite(IfIdWrite), .IfIdFlush(IfIdFlush),
    .IdExBubble(IdExBubble), .ExMemHold(ExMemHold), .MemWbBubble(MemWbBubble),
    .MdStart(MdStart),
`ifdef HAZARD_PERF_EN
    .StallCycles(StallCycles), .FlushCount(FlushCount),
`endif
    .MemErr(MemErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  bit m_busy, m_err;
  int m_wait;
  int m_stalls, m_flushes;

  function automatic bit uses(input logic [4:0] r, input bit use_rt);
    return (r != 0) && (r == IfIdRegRs || (use_rt && r == IfIdRegRt));
  endfunction

  // Which rule wins this cycle: 0 none, 1 mem wait, 2 md, 3 load-use, 4 branch
  function automatic int reason();
    if ((ExMemMemRead || ExMemMemWrite) && !DMemReady) return 1;
    if (m_busy && (IdMulDiv || IdReadsHiLo)) return 2;
    if (IdExMemRead && uses(IdExRegRd, IdUsesRt)) return 3;
    if (IdBranch && ((IdExRegWrite && uses(IdExRegRd, 1)) ||
                     (ExMemMemRead && uses(ExMemRegRd, 1)))) return 4;
    return 0;
  endfunction

  // {PcWrite,IfIdWrite,IfIdFlush,IdExBubble,ExMemHold,MemWbBubble,MdStart,MemErr}
  function automatic logic [7:0] expected();
    int r;
    if (!rst_n) return 8'b1100_0000;
    r = reason();
    case (r)
      1:       return {6'b000011, 1'b0, m_err};
      2, 3, 4: return {6'b000100, 1'b0, m_err};
      default: return {2'b11, IdBranch && BranchTaken, 3'b000,
                       IdMulDiv && !m_busy, m_err};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare this cycle's outputs, clock once, advance the model.
  task automatic tick(input string tag);
    logic [7:0] exp;
    int r;
    exp = expected();
    #3;
    check(tag, {PcWrite, IfIdWrite, IfIdFlush, IdExBubble, ExMemHold, MemWbBubble, MdStart, MemErr}, exp);
`ifdef HAZARD_PERF_EN
    check({tag, "_stalls"}, StallCycles, m_stalls);
    check({tag, "_flushes"}, FlushCount, m_flushes);
`endif
    r = reason();
    @(posedge clk);
    if (rst_n) begin
      if (exp[7] == 1'b0) m_stalls++;
      if (exp[5]) m_flushes++;
      if (r == 1) begin
        if (m_wait < TO) m_wait++;
        if (m_wait >= TO) m_err = 1;
      end else m_wait = 0;
      if (exp[1]) m_busy = 1;
      else if (MdDone) m_busy = 0;
    end
    #1;
  endtask

  task automatic idle();
    IfIdRegRs = 0; IfIdRegRt = 0; IdUsesRt = 0; IdBranch = 0; BranchTaken = 0;
    IdMulDiv = 0; IdReadsHiLo = 0; IdExMemRead = 0; IdExRegWrite = 0; IdExRegRd = 0;
    ExMemMemRead = 0; ExMemMemWrite = 0; ExMemRegRd = 0; DMemReady = 1; MdDone = 0;
  endtask

  task automatic do_reset(input bit release_after);
    rst_n = 0;
    m_busy = 0; m_err = 0; m_wait = 0; m_stalls = 0; m_flushes = 0;
    tick("reset");
    if (release_after) rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    @(posedge clk); #1;
    do_reset(1);
    tick("idle");

    // Load-use: lw $2 in EX, ID reads rs=2 -> one stall then normal
    IdExMemRead = 1; IdExRegWrite = 1; IdExRegRd = 2; IfIdRegRs = 2;
    tick("lu_stall");
    idle(); IfIdRegRs = 2; tick("lu_release");

    // Branch on load result: EX then MEM stage, then taken flush
    idle(); IdBranch = 1; BranchTaken = 1; IfIdRegRs = 3; IfIdRegRt = 4;
    IdExMemRead = 1; IdExRegWrite = 1; IdExRegRd = 4;
    tick("br_ex");
    IdExMemRead = 0; IdExRegWrite = 0; IdExRegRd = 0;
    ExMemMemRead = 1; ExMemRegRd = 4;
    tick("br_mem");
    ExMemMemRead = 0; ExMemRegRd = 0;
    tick("br_flush");
    idle(); tick("br_after");

    // Zero destination never stalls
    IdBranch = 1; IdExMemRead = 1; IdExRegWrite = 1; IdExRegRd = 0; IfIdRegRs = 0;
    tick("rd_zero");

    // mult then mflo: stall until the MdDone cycle, release next cycle
    idle(); IdMulDiv = 1; tick("md_start");
    idle(); IdReadsHiLo = 1; tick("md_wait1");
    tick("md_wait2");
    MdDone = 1; tick("md_done");
    MdDone = 0; tick("md_release");

    // Stalled mult coinciding with MdDone starts the following cycle
    idle(); IdMulDiv = 1; tick("md2_start");
    tick("md2_stall");
    MdDone = 1; tick("md2_done");
    MdDone = 0; tick("md2_restart");
    idle(); tick("md2_gap");

    // Reset mid mul/div: busy drops, stray MdDone ignored
    IdMulDiv = 1; tick("md3_start");
    idle(); do_reset(0);
    rst_n = 1; IdReadsHiLo = 1; MdDone = 1; tick("md3_after_rst");
    idle(); tick("md3_idle");

    // 3 wait cycles: frozen, no error
    ExMemMemRead = 1; DMemReady = 0;
    for (int i = 0; i < 3; i++) tick("mwait");
    DMemReady = 1; tick("mwait_done");

    // Timeout: error after TO wait cycles, sticky until reset
    ExMemMemWrite = 1; ExMemMemRead = 0; DMemReady = 0;
    for (int i = 0; i < TO + 2; i++) tick("mto_wait");
    idle(); tick("mto_sticky1");
    tick("mto_sticky2");
    do_reset(1);
    tick("mto_cleared");

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      IfIdRegRs     = 5'($urandom_range(0, 3));
      IfIdRegRt     = 5'($urandom_range(0, 3));
      IdExRegRd     = 5'($urandom_range(0, 3));
      ExMemRegRd    = 5'($urandom_range(0, 3));
      IdUsesRt      = 1'($urandom);
      IdBranch      = ($urandom_range(0, 3) == 0);
      BranchTaken   = 1'($urandom);
      IdMulDiv      = ($urandom_range(0, 4) == 0);
      IdReadsHiLo   = ($urandom_range(0, 4) == 0);
      IdExMemRead   = ($urandom_range(0, 2) == 0);
      IdExRegWrite  = 1'($urandom);
      ExMemMemRead  = ($urandom_range(0, 3) == 0);
      ExMemMemWrite = ($urandom_range(0, 5) == 0);
      DMemReady     = ($urandom_range(0, 3) != 0);
      MdDone        = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) do_reset(1);
      else tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
